// File: rtl/serial_mod_n_pkg.sv
// Shared types and helpers for the serial mod-N divisibility detector.
// Holds arrival-order encoding, intermediate width and pow seed function.
package serial_mod_n_pkg;

    typedef enum logic {
        MODE_MSB = 1'b0,
        MODE_LSB = 1'b1
    } mode_e;

    // Width of the pre-reduction intermediates (2*rem+bit, rem+pow, 2*pow).
    function automatic int ext_w(input int w);
        return w + 1;
    endfunction

    // 2^0 mod N; N==0 is a config error, so its seed value is irrelevant.
    function automatic logic mod_init_pow(input int unsigned n);
        return (n != 1);
    endfunction

endpackage

// File: rtl/mod_n_reduce.sv
// Single conditional subtract: y = (a >= n) ? a - n : a.
// Valid as a full modulo only when a < 2n, which the callers guarantee.
module mod_n_reduce
    import serial_mod_n_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] n,
    output logic [W-1:0] y
);

    logic [W:0] n_ext;
    logic [W:0] diff;

    assign n_ext = {1'b0, n};
    assign diff  = a - n_ext;

    always_comb begin
        y = a[W-1:0];
        if (a >= n_ext) begin
            y = diff[W-1:0];
        end
    end

endmodule

// File: rtl/serial_mod_n_detector.sv
// Serial bit-stream remainder tracker modulo a programmable divisor.
// Outputs are registers only; clr restarts the stream and may consume a bit.
module serial_mod_n_detector
    import serial_mod_n_pkg::*;
#(
    parameter int   W       = 8,
    parameter int   CNTW    = 16,
    parameter int   DEF_DIV = 4,
    parameter logic DEF_LSB = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [W-1:0]    div_in,
    input  logic            lsb_first_in,
    input  logic            bit_valid,
    input  logic            bit_in,
    output logic            divisible,
    output logic [W-1:0]    remainder,
    output logic [CNTW-1:0] bit_count,
    output logic            cfg_err
);

    localparam int XW = ext_w(W);

    localparam logic [W-1:0] RST_DIV = W'(DEF_DIV);
    localparam logic [W-1:0] RST_POW = W'(mod_init_pow(DEF_DIV));
    localparam logic         RST_ERR = (DEF_DIV == 0);

    logic [W-1:0] n_reg;
    logic [W-1:0] pow;
    mode_e        mode;

    // Effective state for this edge: clr substitutes a fresh stream.
    logic [W-1:0]    n_eff;
    logic [W-1:0]    rem_eff;
    logic [W-1:0]    pow_eff;
    logic [CNTW-1:0] cnt_eff;
    mode_e           mode_eff;
    logic            err_eff;

    logic [XW-1:0]   t_rem;
    logic [XW-1:0]   t_pow;
    logic [W-1:0]    rem_red;
    logic [W-1:0]    pow_red;

    logic            consume;
    logic [W-1:0]    rem_nxt;
    logic [W-1:0]    pow_nxt;
    logic [CNTW-1:0] cnt_nxt;
    logic            div_nxt;

    always_comb begin
        n_eff    = n_reg;
        rem_eff  = remainder;
        pow_eff  = pow;
        cnt_eff  = bit_count;
        mode_eff = mode;
        err_eff  = cfg_err;
        if (clr) begin
            n_eff    = div_in;
            rem_eff  = '0;
            pow_eff  = W'(mod_init_pow(int'(div_in)));
            cnt_eff  = '0;
            mode_eff = mode_e'(lsb_first_in);
            err_eff  = (div_in == '0);
        end
    end

    always_comb begin
        t_rem = {rem_eff, bit_in};
        if (mode_eff == MODE_LSB) begin
            t_rem = {1'b0, rem_eff} + (bit_in ? {1'b0, pow_eff} : '0);
        end
        t_pow = {pow_eff, 1'b0};
    end

    mod_n_reduce #(.W(W)) u_rem_reduce (
        .a (t_rem),
        .n (n_eff),
        .y (rem_red)
    );

    mod_n_reduce #(.W(W)) u_pow_reduce (
        .a (t_pow),
        .n (n_eff),
        .y (pow_red)
    );

    assign consume = bit_valid && !err_eff;

    always_comb begin
        rem_nxt = rem_eff;
        pow_nxt = pow_eff;
        cnt_nxt = cnt_eff;
        if (consume) begin
            rem_nxt = rem_red;
            if (mode_eff == MODE_LSB) begin
                pow_nxt = pow_red;
            end
            if (!(&cnt_eff)) begin
                cnt_nxt = cnt_eff + CNTW'(1);
            end
        end
        div_nxt = (cnt_nxt != '0) && (rem_nxt == '0) && !err_eff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg     <= RST_DIV;
            mode      <= mode_e'(DEF_LSB);
            pow       <= RST_POW;
            remainder <= '0;
            bit_count <= '0;
            divisible <= 1'b0;
            cfg_err   <= RST_ERR;
        end else begin
            n_reg     <= n_eff;
            mode      <= mode_eff;
            pow       <= pow_nxt;
            remainder <= rem_nxt;
            bit_count <= cnt_nxt;
            divisible <= div_nxt;
            cfg_err   <= err_eff;
        end
    end

endmodule

// File: tb/tb_serial_mod_n_detector.sv
// Directed bench for serial_mod_n_detector with hand-computed expectations.
// A second instance with a 4-bit counter shares the stimulus for saturation.
module tb_serial_mod_n_detector;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] div_in;
    logic       lsb_first_in;
    logic       bit_valid;
    logic       bit_in;

    logic        divisible;
    logic [7:0]  remainder;
    logic [15:0] bit_count;
    logic        cfg_err;

    logic        s_divisible;
    logic [7:0]  s_remainder;
    logic [3:0]  s_bit_count;
    logic        s_cfg_err;

    int vecs  = 0;
    int fails = 0;

    serial_mod_n_detector dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .div_in       (div_in),
        .lsb_first_in (lsb_first_in),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .divisible    (divisible),
        .remainder    (remainder),
        .bit_count    (bit_count),
        .cfg_err      (cfg_err)
    );

    serial_mod_n_detector #(.CNTW(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .div_in       (div_in),
        .lsb_first_in (lsb_first_in),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .divisible    (s_divisible),
        .remainder    (s_remainder),
        .bit_count    (s_bit_count),
        .cfg_err      (s_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int rem, input int dv,
                             input int cnt, input int err);
        check({tag, ".rem"}, 32'(remainder), 32'(rem));
        check({tag, ".div"}, 32'(divisible), 32'(dv));
        check({tag, ".cnt"}, 32'(bit_count), 32'(cnt));
        check({tag, ".err"}, 32'(cfg_err), 32'(err));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic c, input logic [7:0] d, input logic l,
                        input logic v, input logic b);
        clr          = c;
        div_in       = d;
        lsb_first_in = l;
        bit_valid    = v;
        bit_in       = b;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        bit_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; div_in = 8'd0;
        lsb_first_in = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        #12;
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // MSB-first N=4 (reset default), value 12
        step(0, 0, 0, 1, 1); check_all("m4_b1", 1, 0, 1, 0);
        step(0, 0, 0, 1, 1); check_all("m4_b2", 3, 0, 2, 0);
        step(0, 0, 0, 1, 0); check_all("m4_b3", 2, 0, 3, 0);
        step(0, 0, 0, 1, 0); check_all("m4_b4", 0, 1, 4, 0);
        step(0, 0, 0, 0, 1); check_all("m4_hold", 0, 1, 4, 0);

        // MSB-first N=3, values 1,3,6
        step(1, 3, 0, 0, 0); check_all("m3_clr", 0, 0, 0, 0);
        step(0, 0, 0, 1, 1); check_all("m3_b1", 1, 0, 1, 0);
        step(0, 0, 0, 1, 1); check_all("m3_b2", 0, 1, 2, 0);
        step(0, 0, 0, 1, 0); check_all("m3_b3", 0, 1, 3, 0);

        // LSB-first N=5, value 5 (pow 1,2,4,3)
        step(1, 5, 1, 0, 0); check_all("l5_clr", 0, 0, 0, 0);
        step(0, 0, 0, 1, 1); check_all("l5_b1", 1, 0, 1, 0);
        step(0, 0, 0, 1, 0); check_all("l5_b2", 1, 0, 2, 0);
        step(0, 0, 0, 1, 1); check_all("l5_b3", 0, 1, 3, 0);

        // clr and bit in the same cycle, N=7
        step(1, 7, 0, 1, 1); check_all("c7_same", 1, 0, 1, 0);
        step(0, 0, 0, 1, 1); check_all("c7_b2", 3, 0, 2, 0);

        // zero divisor: bits ignored until the next clr
        step(1, 0, 0, 0, 0); check_all("z_clr", 0, 0, 0, 1);
        step(0, 0, 0, 1, 1); check_all("z_b1", 0, 0, 0, 1);
        step(0, 0, 0, 1, 0); check_all("z_b2", 0, 0, 0, 1);
        step(0, 0, 0, 1, 1); check_all("z_b3", 0, 0, 0, 1);
        step(1, 1, 0, 0, 0); check_all("n1_clr", 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); check_all("n1_b1", 0, 1, 1, 0);
        step(0, 0, 0, 1, 1); check_all("n1_b2", 0, 1, 2, 0);

        // async reset mid-stream, divisor reverts to 4
        step(1, 3, 1, 1, 1); check_all("r_b1", 1, 0, 1, 0);
        step(0, 0, 0, 1, 1); check_all("r_b2", 0, 1, 2, 0);
        #3 rst = 1'b1;
        #1 check_all("r_async", 0, 0, 0, 0);
        #1 rst = 1'b0;
        step(0, 0, 0, 1, 1); check_all("r4_b1", 1, 0, 1, 0);
        step(0, 0, 0, 1, 0); check_all("r4_b2", 2, 0, 2, 0);
        step(0, 0, 0, 1, 0); check_all("r4_b3", 0, 1, 3, 0);

        // 20 ones MSB-first mod 7: remainder cycles 1,3,0; ends at 3
        step(1, 7, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 1, 1);
            if (i == 15) begin
                check("sat_at15", 32'(s_bit_count), 32'd15);
                check("sat_rem15", 32'(s_remainder), 32'd0);
            end
            if (i == 16) begin
                check("sat_at16", 32'(s_bit_count), 32'd15);
            end
        end
        check("sat_cnt", 32'(s_bit_count), 32'd15);
        check("sat_rem", 32'(s_remainder), 32'd3);
        check("sat_div", 32'(s_divisible), 32'd0);
        check_all("wide_20", 3, 0, 20, 0);
        step(0, 0, 0, 1, 0);
        check("sat_rem21", 32'(s_remainder), 32'd6);
        check("sat_cnt21", 32'(s_bit_count), 32'd15);
        step(0, 0, 0, 1, 1);
        check("sat_rem22", 32'(s_remainder), 32'd6);
        check("sat_div22", 32'(s_divisible), 32'd0);
        step(0, 0, 0, 1, 1);
        check("sat_rem23", 32'(s_remainder), 32'd6);
        step(0, 0, 0, 1, 0);
        check("sat_rem24", 32'(s_remainder), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/serial_mod_n_detector.md
Name: serial_mod_n_detector

Overview:
Serial bit-stream divisibility detector, generalised from the fixed divide-by-4 Moore FSM.
- Tracks the remainder of the number received so far modulo a runtime-programmable divisor N.
- Supports MSB-first and LSB-first arrival and a bit-valid qualifier.
- Sits behind serial front-ends (UART/SPI deserialisers) to flag stream values as they complete.

Parameters:
W, 8, divisor/remainder width; legal divisor range 1..2^W-1
CNTW, 16, bit_count width; counter saturates
DEF_DIV, 4, divisor loaded at reset
DEF_LSB, 0, arrival order at reset (0 = MSB-first, 1 = LSB-first)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
clr  in  1  sync start-of-number; latches div_in and lsb_first_in, clears stream state
div_in  in  W  divisor N, sampled only when clr=1
lsb_first_in  in  1  arrival order, sampled only when clr=1
bit_valid  in  1  bit_in is consumed on this edge
bit_in  in  1  serial data bit
divisible  out  1  registered; 1 when at least one bit received and remainder==0 and no cfg_err
remainder  out  W  registered current value mod N
bit_count  out  CNTW  registered bits consumed since clr/reset, saturating at all-ones
cfg_err  out  1  registered; 1 while latched divisor==0

Behaviour:
- Reset values: N_reg=DEF_DIV, mode=DEF_LSB, remainder=0, pow=(1 mod DEF_DIV), bit_count=0, divisible=0, cfg_err=(DEF_DIV==0).
- Latency: a bit consumed at edge k is reflected in all outputs immediately after edge k. This is Moore-style: outputs are registers only, with no combinational path from bit_in.
- MSB-first update: t=2*rem+bit (W+1 bits); rem' = (t>=N) ? t-N : t. A single conditional subtract suffices because rem<N.
- LSB-first update: pow holds 2^k mod N for the next bit position.
  - t=rem+(bit?pow:0); rem' = (t>=N) ? t-N : t.
  - u=2*pow; pow' = (u>=N) ? u-N : u.
  - pow advances on every consumed bit, including 0-bits.
- All intermediates are W+1 bits wide; no divider or modulo operator is permitted.
- divisible' = (bit_count' != 0) && (rem' == 0) && !cfg_err'. An empty stream is never divisible, matching the legacy S0 behaviour.
- bit_count increments by 1 per consumed bit and holds at 2^CNTW-1. Remainder tracking continues past saturation.
- clr=1 (with or without bit_valid):
  - latches N_reg=div_in and mode=lsb_first_in;
  - sets rem=0, pow=(div_in==1 ? 0 : 1), bit_count=0, cfg_err=(div_in==0).
- clr=1 and bit_valid=1 in the same cycle: clr wins. The bit is then consumed as the first bit of the new number, under the new N and mode.
  - Outputs after that edge: bit_count=1, remainder=(bit mod N).
- N==1: remainder stays 0, and divisible=1 from the first consumed bit onward.
- cfg_err=1: bits are ignored; rem, pow and bit_count hold; divisible=0. Only clr or rst clears cfg_err.
- bit_valid=0 and clr=0: all state holds.
- rst mid-stream: immediate return to reset values regardless of clk. The divisor reverts to DEF_DIV.

Decomposition:
- Package serial_mod_n_pkg:
  - MODE_MSB=1'b0 and MODE_LSB=1'b1;
  - width helpers (W+1 intermediate width);
  - the function mod_init_pow(N).
- One sub-module, mod_n_reduce: a combinational "a (W+1 bits), N -> a>=N ? a-N : a" reducer.
  - Instantiated twice: remainder path and pow path.
- Top level holds the registers, the clr/cfg_err control and the bit_count saturation.

Test Plan:
- MSB-first N=4 after reset, bits 1,1,0,0 -> remainder 1,3,2,0; divisible 0,0,0,1; bit_count 4 (value 12).
- clr with div_in=3, MSB-first, bits 1,1,0 -> remainder 1,0,0; divisible 0,1,1 (values 1,3,6).
- clr with div_in=5, lsb_first_in=1, bits 1,0,1 -> remainder 1,1,0; divisible 0,0,1 (value 5). Internal pow sequence 1,2,4,3.
- clr and bit_valid=1 with bit_in=1, div_in=7, in one cycle -> bit_count=1, remainder=1, divisible=0. Prior stream state is discarded.
- clr with div_in=0, then 3 bits -> cfg_err=1, divisible=0, bit_count=0. A following clr with div_in=1 plus one 0-bit -> cfg_err=0, divisible=1.
- Assert rst asynchronously mid-stream at a non-edge time -> outputs reset immediately and N reverts to 4.
- Additional run with CNTW=4, 20 bits -> bit_count saturates at 15 while the remainder stays correct.
